// File: rtl/mips_cpu.sv
// mips_cpu: 5-stage MIPS-subset core (F/D/E/M/W) with D-stage branches,
// full forwarding, and load/ALU hazard stalls.
module mips_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] m_data_addr,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_inst_addr,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr
);

  localparam logic [5:0] OP_RT  = 6'h00;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_JR  = 6'h08;

  function automatic logic f_add(input logic [31:0] i);
    return i[31:26] == OP_RT && i[5:0] == FN_ADD;
  endfunction

  function automatic logic f_sub(input logic [31:0] i);
    return i[31:26] == OP_RT && i[5:0] == FN_SUB;
  endfunction

  function automatic logic f_jr(input logic [31:0] i);
    return i[31:26] == OP_RT && i[5:0] == FN_JR;
  endfunction

  function automatic logic f_load(input logic [31:0] i);
    return i[31:26] == OP_LW || i[31:26] == OP_LH
        || i[31:26] == OP_LB;
  endfunction

  function automatic logic f_store(input logic [31:0] i);
    return i[31:26] == OP_SW || i[31:26] == OP_SH
        || i[31:26] == OP_SB;
  endfunction

  function automatic logic f_br(input logic [31:0] i);
    return i[31:26] == OP_BEQ || i[31:26] == OP_BNE;
  endfunction

  // lui and jal results are known as soon as they enter E
  function automatic logic f_early(input logic [31:0] i);
    return i[31:26] == OP_LUI || i[31:26] == OP_JAL;
  endfunction

  function automatic logic f_wr(input logic [31:0] i);
    return f_add(i) || f_sub(i) || f_load(i) || f_early(i)
        || i[31:26] == OP_ORI;
  endfunction

  function automatic logic [4:0] f_dst(input logic [31:0] i);
    logic [4:0] r;
    r = 5'd0;
    if (f_add(i) || f_sub(i)) r = i[15:11];
    else if (i[31:26] == OP_JAL) r = 5'd31;
    else if (f_wr(i)) r = i[20:16];
    return r;
  endfunction

  logic [31:0] pc_q, pc_d;
  logic [31:0] fd_instr_q, fd_pc_q;
  logic [31:0] de_instr_q, de_pc_q, de_rs_q, de_rt_q;
  logic [31:0] em_instr_q, em_pc_q, em_res_q, em_rt_q;
  logic [31:0] mw_instr_q, mw_pc_q, mw_res_q;
  logic [31:0] grf_q [32];

  logic        w_we;
  logic [4:0]  w_dst;
  assign w_we  = f_wr(mw_instr_q);
  assign w_dst = f_dst(mw_instr_q);

  logic        e_wr, e_rdy, e_ld;
  logic [4:0]  e_dst;
  logic [31:0] e_val;
  assign e_wr  = f_wr(de_instr_q);
  assign e_rdy = f_early(de_instr_q);
  assign e_ld  = f_load(de_instr_q);
  assign e_dst = f_dst(de_instr_q);
  assign e_val = (de_instr_q[31:26] == OP_JAL)
               ? de_pc_q + 32'd8
               : {de_instr_q[15:0], 16'h0000};

  logic        m_wr, m_ld;
  logic [4:0]  m_dst;
  assign m_wr  = f_wr(em_instr_q);
  assign m_ld  = f_load(em_instr_q);
  assign m_dst = f_dst(em_instr_q);

  // D stage
  logic [4:0]  d_rs, d_rt;
  logic [31:0] d_rs_raw, d_rt_raw, d_rs_v, d_rt_v;
  assign d_rs = fd_instr_q[25:21];
  assign d_rt = fd_instr_q[20:16];

  assign d_rs_raw = (d_rs == 5'd0) ? 32'h0
                  : (w_we && w_dst == d_rs) ? mw_res_q
                  : grf_q[d_rs];
  assign d_rt_raw = (d_rt == 5'd0) ? 32'h0
                  : (w_we && w_dst == d_rt) ? mw_res_q
                  : grf_q[d_rt];

  assign d_rs_v = (d_rs == 5'd0) ? 32'h0
                : (e_wr && e_dst == d_rs) ? e_val
                : (m_wr && m_dst == d_rs) ? em_res_q
                : d_rs_raw;
  assign d_rt_v = (d_rt == 5'd0) ? 32'h0
                : (e_wr && e_dst == d_rt) ? e_val
                : (m_wr && m_dst == d_rt) ? em_res_q
                : d_rt_raw;

  logic d_br, d_jr, d_jal;
  logic use_rs_d, use_rt_d, use_rs_e, use_rt_e;
  assign d_br  = f_br(fd_instr_q);
  assign d_jr  = f_jr(fd_instr_q);
  assign d_jal = fd_instr_q[31:26] == OP_JAL;

  assign use_rs_d = d_br || d_jr;
  assign use_rt_d = d_br;
  assign use_rs_e = f_add(fd_instr_q) || f_sub(fd_instr_q)
                 || f_load(fd_instr_q) || f_store(fd_instr_q)
                 || fd_instr_q[31:26] == OP_ORI;
  assign use_rt_e = f_add(fd_instr_q) || f_sub(fd_instr_q);

  logic stall_rs, stall_rt, stall;
  assign stall_rs = d_rs != 5'd0 && (
      (use_rs_d && ((e_wr && e_dst == d_rs && !e_rdy)
                 || (m_ld && m_dst == d_rs)))
   || (use_rs_e && e_ld && e_dst == d_rs));
  assign stall_rt = d_rt != 5'd0 && (
      (use_rt_d && ((e_wr && e_dst == d_rt && !e_rdy)
                 || (m_ld && m_dst == d_rt)))
   || (use_rt_e && e_ld && e_dst == d_rt));
  assign stall = stall_rs || stall_rt;

  logic        d_take, d_go;
  logic [31:0] d_sext, d_btgt, d_jtgt;
  assign d_take = (fd_instr_q[31:26] == OP_BEQ && d_rs_v == d_rt_v)
               || (fd_instr_q[31:26] == OP_BNE && d_rs_v != d_rt_v);
  assign d_go   = !stall;
  assign d_sext = {{16{fd_instr_q[15]}}, fd_instr_q[15:0]};
  assign d_btgt = fd_pc_q + 32'd4 + (d_sext << 2);
  assign d_jtgt = {fd_pc_q[31:28], fd_instr_q[25:0], 2'b00};

  always_comb begin
    pc_d = pc_q + 32'd4;
    unique case (1'b1)
      stall:           pc_d = pc_q;
      d_go && d_jal:   pc_d = d_jtgt;
      d_go && d_jr:    pc_d = d_rs_v;
      d_go && d_take:  pc_d = d_btgt;
      default: ;
    endcase
  end

  // E stage
  logic [4:0]  e_rs, e_rt;
  logic [31:0] e_rs_v, e_rt_v, e_sext, e_res;
  assign e_rs = de_instr_q[25:21];
  assign e_rt = de_instr_q[20:16];

  assign e_rs_v = (e_rs != 5'd0 && m_wr && m_dst == e_rs) ? em_res_q
                : (e_rs != 5'd0 && w_we && w_dst == e_rs) ? mw_res_q
                : de_rs_q;
  assign e_rt_v = (e_rt != 5'd0 && m_wr && m_dst == e_rt) ? em_res_q
                : (e_rt != 5'd0 && w_we && w_dst == e_rt) ? mw_res_q
                : de_rt_q;
  assign e_sext = {{16{de_instr_q[15]}}, de_instr_q[15:0]};

  always_comb begin
    e_res = 32'h0;
    unique case (1'b1)
      f_load(de_instr_q) || f_store(de_instr_q):
        e_res = e_rs_v + e_sext;
      f_add(de_instr_q):
        e_res = e_rs_v + e_rt_v;
      f_sub(de_instr_q):
        e_res = e_rs_v - e_rt_v;
      de_instr_q[31:26] == OP_ORI:
        e_res = e_rs_v | {16'h0, de_instr_q[15:0]};
      e_rdy:
        e_res = e_val;
      default: ;
    endcase
  end

  // M stage: a load sitting in W may still owe this store its data
  logic [4:0]  m_rt;
  logic [31:0] m_st_v, m_wd, m_res;
  logic [3:0]  m_be;
  logic [4:0]  m_sh;
  logic [7:0]  m_byte;
  logic [15:0] m_half;
  logic [5:0]  m_op;
  assign m_op = em_instr_q[31:26];
  assign m_rt = em_instr_q[20:16];
  assign m_sh = {em_res_q[1:0], 3'b000};
  assign m_st_v = (m_rt != 5'd0 && w_we && w_dst == m_rt)
                ? mw_res_q : em_rt_q;

  always_comb begin
    m_be = 4'b0000;
    m_wd = 32'h0;
    unique case (1'b1)
      m_op == OP_SW: begin
        m_be = 4'b1111;
        m_wd = m_st_v;
      end
      m_op == OP_SH: begin
        m_be = 4'b0011 << em_res_q[1:0];
        m_wd = {16'h0, m_st_v[15:0]} << m_sh;
      end
      m_op == OP_SB: begin
        m_be = 4'b0001 << em_res_q[1:0];
        m_wd = {24'h0, m_st_v[7:0]} << m_sh;
      end
      default: ;
    endcase
  end

  always_comb begin
    m_byte = m_data_rdata[7:0];
    unique case (em_res_q[1:0])
      2'd1: m_byte = m_data_rdata[15:8];
      2'd2: m_byte = m_data_rdata[23:16];
      2'd3: m_byte = m_data_rdata[31:24];
      default: ;
    endcase
  end
  assign m_half = em_res_q[1] ? m_data_rdata[31:16]
                              : m_data_rdata[15:0];

  always_comb begin
    m_res = em_res_q;
    unique case (1'b1)
      m_op == OP_LW: m_res = m_data_rdata;
      m_op == OP_LH: m_res = {{16{m_half[15]}}, m_half};
      m_op == OP_LB: m_res = {{24{m_byte[7]}}, m_byte};
      default: ;
    endcase
  end

  // pipeline state
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      fd_instr_q <= 32'h0;
      fd_pc_q    <= 32'h0;
      de_instr_q <= 32'h0;
      de_pc_q    <= 32'h0;
      de_rs_q    <= 32'h0;
      de_rt_q    <= 32'h0;
      em_instr_q <= 32'h0;
      em_pc_q    <= 32'h0;
      em_res_q   <= 32'h0;
      em_rt_q    <= 32'h0;
      mw_instr_q <= 32'h0;
      mw_pc_q    <= 32'h0;
      mw_res_q   <= 32'h0;
    end else begin
      pc_q <= pc_d;
      if (!stall) begin
        fd_instr_q <= i_inst_rdata;
        fd_pc_q    <= pc_q;
        de_instr_q <= fd_instr_q;
        de_pc_q    <= fd_pc_q;
        de_rs_q    <= d_rs_v;
        de_rt_q    <= d_rt_v;
      end else begin
        de_instr_q <= 32'h0;
        de_pc_q    <= 32'h0;
        de_rs_q    <= 32'h0;
        de_rt_q    <= 32'h0;
      end
      em_instr_q <= de_instr_q;
      em_pc_q    <= de_pc_q;
      em_res_q   <= e_res;
      em_rt_q    <= e_rt_v;
      mw_instr_q <= em_instr_q;
      mw_pc_q    <= em_pc_q;
      mw_res_q   <= m_res;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) grf_q[i] <= 32'h0;
    end else if (w_we && w_dst != 5'd0) begin
      grf_q[w_dst] <= mw_res_q;
    end
  end

  assign i_inst_addr   = pc_q;
  assign m_data_addr   = em_res_q;
  assign m_data_wdata  = m_wd;
  assign m_data_byteen = reset ? 4'b0000 : m_be;
  assign m_inst_addr   = reset ? 32'h0 : em_pc_q;
  assign w_grf_we      = !reset && w_we;
  assign w_grf_addr    = reset ? 5'd0 : w_dst;
  assign w_grf_wdata   = reset ? 32'h0 : mw_res_q;
  assign w_inst_addr   = reset ? 32'h0 : mw_pc_q;

endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: directed programs for mips_cpu with a simple
// instruction/data memory and a W-stage trace checker.
module tb_mips_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_inst_addr, i_inst_rdata;
  logic [31:0] m_data_addr, m_data_rdata, m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata, w_inst_addr;

  int checks = 0;
  int failures = 0;

  mips_cpu #(.RESET_PC(32'h0000_3000)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_inst_addr   (i_inst_addr),
    .i_inst_rdata  (i_inst_rdata),
    .m_data_addr   (m_data_addr),
    .m_data_rdata  (m_data_rdata),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .w_grf_we      (w_grf_we),
    .w_grf_addr    (w_grf_addr),
    .w_grf_wdata   (w_grf_wdata),
    .w_inst_addr   (w_inst_addr)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  logic        mem_clr = 1'b1;
  logic [31:0] ioff;

  assign ioff = i_inst_addr - 32'h0000_3000;
  assign i_inst_rdata = (ioff < 32'd256) ? imem[ioff[7:2]] : 32'h0;
  assign m_data_rdata = dmem[m_data_addr[7:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (m_data_byteen[b])
          dmem[m_data_addr[7:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
    end
  end

  logic [67:0] st_q [$];
  always @(negedge clk)
    if (!reset && m_data_byteen != 4'b0000)
      st_q.push_back({m_data_addr, m_data_byteen, m_data_wdata});

  function automatic logic [31:0] ienc(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt,
      input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] renc(input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd,
      input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
      input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for the next retiring instruction (non-zero W PC).
  task automatic next_w(input logic [31:0] pc, input logic we,
      input logic [4:0] a, input logic [31:0] d, input int gap);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (w_inst_addr == 32'h0 && n < 12);
    chk($sformatf("w_pc@%h", pc), w_inst_addr, pc);
    chk($sformatf("gap@%h", pc), n, gap);
    chk($sformatf("we@%h", pc), {31'h0, w_grf_we}, {31'h0, we});
    if (we) begin
      chk($sformatf("waddr@%h", pc), {27'h0, w_grf_addr}, {27'h0, a});
      chk($sformatf("wdata@%h", pc), w_grf_wdata, d);
    end
  endtask

  task automatic chk_st(input logic [31:0] a, input logic [3:0] be,
      input logic [31:0] wd);
    logic [67:0] s;
    s = '1;
    if (st_q.size() > 0) s = st_q.pop_front();
    chk($sformatf("st_addr %h", a), s[67:36], a);
    chk($sformatf("st_be %h", a), {28'h0, s[35:32]}, {28'h0, be});
    chk($sformatf("st_wd %h", a), s[31:0], wd);
  endtask

  task automatic clr_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  initial begin
    clr_imem();
    imem[0]  = ienc(6'h0d, 0, 1, 16'h1234);
    imem[1]  = ienc(6'h0d, 0, 2, 16'h0001);
    imem[2]  = renc(1, 2, 3, 6'h20);
    imem[3]  = ienc(6'h0f, 0, 4, 16'hffff);
    imem[4]  = ienc(6'h2b, 0, 4, 16'h0008);
    imem[5]  = ienc(6'h23, 0, 5, 16'h0008);
    imem[6]  = renc(5, 5, 6, 6'h20);
    imem[7]  = ienc(6'h28, 0, 1, 16'h0001);
    imem[8]  = ienc(6'h20, 0, 7, 16'h0001);
    imem[9]  = ienc(6'h29, 0, 1, 16'h0002);
    imem[10] = renc(2, 1, 10, 6'h22);
    imem[11] = ienc(6'h29, 0, 10, 16'h0000);
    imem[12] = ienc(6'h21, 0, 11, 16'h0000);
    imem[13] = ienc(6'h20, 0, 12, 16'h0003);
    imem[14] = ienc(6'h23, 0, 13, 16'h0000);
    imem[15] = ienc(6'h20, 0, 14, 16'h0003);
    imem[16] = ienc(6'h28, 0, 14, 16'h0005);
    imem[17] = ienc(6'h23, 0, 15, 16'h0004);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", i_inst_addr, 32'h3000);
    chk("rst_we", {31'h0, w_grf_we}, 32'h0);
    chk("rst_waddr", {27'h0, w_grf_addr}, 32'h0);
    chk("rst_wdata", w_grf_wdata, 32'h0);
    chk("rst_wpc", w_inst_addr, 32'h0);
    chk("rst_mpc", m_inst_addr, 32'h0);
    chk("rst_be", {28'h0, m_data_byteen}, 32'h0);
    mem_clr = 1'b0;
    reset = 1'b0;

    next_w(32'h3000, 1, 1,  32'h0000_1234, 4);
    next_w(32'h3004, 1, 2,  32'h0000_0001, 1);
    next_w(32'h3008, 1, 3,  32'h0000_1235, 1);
    next_w(32'h300c, 1, 4,  32'hffff_0000, 1);
    next_w(32'h3010, 0, 0,  32'h0, 1);
    next_w(32'h3014, 1, 5,  32'hffff_0000, 1);
    next_w(32'h3018, 1, 6,  32'hfffe_0000, 2);
    next_w(32'h301c, 0, 0,  32'h0, 1);
    next_w(32'h3020, 1, 7,  32'h0000_0034, 1);
    next_w(32'h3024, 0, 0,  32'h0, 1);
    next_w(32'h3028, 1, 10, 32'hffff_edcd, 1);
    next_w(32'h302c, 0, 0,  32'h0, 1);
    next_w(32'h3030, 1, 11, 32'hffff_edcd, 1);
    next_w(32'h3034, 1, 12, 32'h0000_0012, 1);
    next_w(32'h3038, 1, 13, 32'h1234_edcd, 1);
    next_w(32'h303c, 1, 14, 32'h0000_0012, 1);
    next_w(32'h3040, 0, 0,  32'h0, 1);
    next_w(32'h3044, 1, 15, 32'h0000_1200, 1);

    chk_st(32'h8, 4'b1111, 32'hffff_0000);
    chk_st(32'h1, 4'b0010, 32'h0000_3400);
    chk_st(32'h2, 4'b1100, 32'h1234_0000);
    chk_st(32'h0, 4'b0011, 32'h0000_edcd);
    chk_st(32'h5, 4'b0010, 32'h0000_1200);
    chk("dmem0", dmem[0], 32'h1234_edcd);
    chk("dmem1", dmem[1], 32'h0000_1200);
    chk("dmem2", dmem[2], 32'hffff_0000);

    @(negedge clk);
    reset = 1'b1;
    clr_imem();
    imem[0]  = ienc(6'h04, 0, 0, 16'h0002);
    imem[1]  = ienc(6'h0d, 0, 1, 16'h0001);
    imem[2]  = ienc(6'h0d, 0, 2, 16'h0002);
    imem[3]  = ienc(6'h05, 0, 0, 16'h0005);
    imem[4]  = {6'h03, 26'h000_0c08};
    imem[5]  = ienc(6'h0d, 0, 3, 16'h0003);
    imem[6]  = ienc(6'h0d, 0, 5, 16'h0005);
    imem[7]  = ienc(6'h0d, 0, 6, 16'h0006);
    imem[8]  = ienc(6'h0d, 0, 31, 16'h301c);
    imem[9]  = renc(31, 0, 0, 6'h08);
    imem[10] = ienc(6'h0d, 0, 4, 16'h0004);
    imem[11] = ienc(6'h0d, 0, 7, 16'h0007);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    next_w(32'h3000, 0, 0,  32'h0, 4);
    next_w(32'h3004, 1, 1,  32'h0000_0001, 1);
    next_w(32'h300c, 0, 0,  32'h0, 1);
    next_w(32'h3010, 1, 31, 32'h0000_3018, 1);
    next_w(32'h3014, 1, 3,  32'h0000_0003, 1);
    next_w(32'h3020, 1, 31, 32'h0000_301c, 1);
    next_w(32'h3024, 0, 0,  32'h0, 2);
    next_w(32'h3028, 1, 4,  32'h0000_0004, 1);
    next_w(32'h301c, 1, 6,  32'h0000_0006, 1);

    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_we", {31'h0, w_grf_we}, 32'h0);
    chk("mid_wpc", w_inst_addr, 32'h0);
    chk("mid_be", {28'h0, m_data_byteen}, 32'h0);
    @(posedge clk);
    #1;
    chk("mid_pc", i_inst_addr, 32'h3000);
    chk("mid_mpc", m_inst_addr, 32'h0);
    clr_imem();
    imem[0] = renc(1, 2, 3, 6'h20);
    imem[1] = ienc(6'h0d, 0, 8, 16'h0055);
    imem[2] = renc(8, 8, 9, 6'h20);
    @(negedge clk);
    reset = 1'b0;

    next_w(32'h3000, 1, 3, 32'h0000_0000, 4);
    next_w(32'h3004, 1, 8, 32'h0000_0055, 1);
    next_w(32'h3008, 1, 9, 32'h0000_00aa, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_cpu.md
Name: mips_cpu

Overview:
- 5-stage pipelined MIPS-subset CPU with stages F, D, E, M and W.
- Instruction memory and data memory are external and read combinationally; data writes are byte-enabled.
- Exposes the writeback stage (register write and its instruction PC) and the M-stage instruction PC for trace comparison.
- Top-level processor core of the system.

Parameters:
- RESET_PC, 32'h0000_3000, address of the first instruction fetched after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_inst_addr  output  32  F-stage PC.
- i_inst_rdata  input  32  instruction at i_inst_addr, combinational.
- m_data_addr  output  32  M-stage byte address for load/store.
- m_data_rdata  input  32  word at m_data_addr[31:2], combinational.
- m_data_wdata  output  32  store data, already shifted into the addressed byte lanes.
- m_data_byteen  output  4  byte-lane write enables; 0 means no write.
- m_inst_addr  output  32  PC of the instruction currently in M.
- w_grf_we  output  1  W-stage register-file write enable.
- w_grf_addr  output  5  W-stage destination register.
- w_grf_wdata  output  32  W-stage write data.
- w_inst_addr  output  32  PC of the instruction currently in W.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. On reset, PC=RESET_PC, every pipeline register becomes a bubble (nop, PC 0), and GRF entries are cleared to 0.
  - While reset is asserted: m_data_byteen=0, w_grf_we=0, w_grf_addr=0, w_grf_wdata=0, m_inst_addr=0, w_inst_addr=0.
- ISA: add, sub, ori, lui, lw, lh, lb, sw, sh, sb, beq, bne, jal, jr, nop (all-zero word).
  - add/sub wrap without an overflow trap.
  - ori zero-extends its immediate; lui places imm<<16.
  - Loads and stores use sign-extended offsets.
  - Any other encoding executes as nop.
- Branch delay slot: beq, bne, jal and jr always execute the following instruction.
  - Branch target = PC+4+(sext(imm)<<2).
  - jal target = {PC[31:28], idx, 2'b00}; jal writes PC+8 to $31.
  - Branches, jumps and their comparisons resolve in D, so the next fetch uses the target.
- Loads: lb and lh sign-extend the addressed byte/halfword selected by m_data_addr[1:0]. lw ignores the low address bits.
- Store byte enables:
  - sw: byteen=4'b1111.
  - sh: byteen=4'b0011<<addr[1:0]; addr[0] is required to be 0.
  - sb: byteen=4'b0001<<addr[1:0].
  - wdata carries the register data replicated/shifted into the enabled lanes.
- GRF: 32x32.
  - $0 reads as 0 and is never written.
  - Writes happen at the rising edge while in W.
  - A same-cycle read of the register being written in W returns the new value (internal W->D bypass).
- w_grf_we=1 for every register-writing instruction in W, even when w_grf_addr=0.
- Forwarding: operands consumed in D (branch compare, jr) and in E (ALU, store address/data) take the youngest available result.
  - Priority: E (jal PC+8, lui/ALU results once computed), then M, then W.
  - Store data in M is forwarded from W.
- Stall (freeze F and D, insert bubble into E) in these cases:
  - D needs a register written by a load in E or M.
  - D branch/jr needs a register written by an ALU instruction in E.
  - E needs a load result that is still in M (load-use): resolved by stalling in D.
- Latency: instruction at PC p appears on w_inst_addr exactly 4 cycles after being fetched, absent stalls.

Test Plan:
- Reset then ori $1,$0,0x1234; ori $2,$0,0x0001; add $3,$1,$2 -> W trace: $1<=00001234, $2<=00000001, $3<=00001235 (E->E forwarding, no stall).
- lui $4,0xffff; sw $4,8($0); lw $5,8($0); add $6,$5,$5 -> store *00000008<=ffff0000 with byteen 1111; $5<=ffff0000; one-cycle load-use stall; $6<=fffe0000.
- sb $1,1($0) with $1=0x1234 and mem[0]=0 -> byteen 0010, stored word 00003400; then lb $7,1($0) -> $7<=00000034. sh to addr 2 -> byteen 1100.
- beq $0,$0,+2 at 0x3000 -> delay slot 0x3004 executes; 0x3008 is skipped; next W PC is 0x300c. bne with equal operands falls through.
- jal to 0x3020 at 0x3010 -> $31<=00003018, delay slot 0x3014 executes; jr $31 immediately after a dependent ori $31 -> stall until forwarded, correct return target.
- Assert reset mid-program -> within one edge all outputs return to reset values; fetch restarts at 0x3000.
